// File: rtl/mult_result_fifo.sv
// Result buffer behind the bit-serial multiplier: captures each finished product
// into a first-word-fall-through FIFO and hands results out over valid/ready.
module mult_result_fifo #(
    parameter int NB_DATA = 4,
    parameter int DEPTH   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_mult_done,
    input  logic [2*NB_DATA-1:0]    i_product,
    output logic [2*NB_DATA-1:0]    o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    input  logic                    i_clr_ovf
);

    localparam int NB_PROD = 2 * NB_DATA;
    localparam int NB_PTR  = $clog2(DEPTH);
    localparam int NB_CNT  = NB_PTR + 1;

    localparam logic [NB_PTR-1:0] PTR_ONE   = NB_PTR'(1);
    localparam logic [NB_CNT-1:0] CNT_ONE   = NB_CNT'(1);
    localparam logic [NB_CNT-1:0] CNT_DEPTH = NB_CNT'(DEPTH);

    logic [NB_PROD-1:0] mem [DEPTH];
    logic [NB_PTR-1:0]  wr_ptr;
    logic [NB_PTR-1:0]  rd_ptr;
    logic [NB_CNT-1:0]  count;
    logic               overflow;
    logic               push;
    logic               pop;
    logic               drop;

    always_comb begin
        o_empty = (count == '0);
        o_full  = (count == CNT_DEPTH);
        o_valid = !o_empty;
        pop     = o_valid && i_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push    = i_mult_done && (!o_full || pop);
        drop    = i_mult_done && o_full && !pop;
        o_data  = o_valid ? mem[rd_ptr] : '0;
        o_count = count;
        o_overflow = overflow;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            // A drop in the clearing cycle keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_product;
        end
    end

endmodule

// File: tb/tb_mult_result_fifo.sv
// Directed, table-driven bench for mult_result_fifo (NB_DATA=4, DEPTH=4).
module tb_mult_result_fifo;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_mult_done;
    logic [7:0] i_product;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_full;
    logic       o_empty;
    logic [2:0] o_count;
    logic       o_overflow;
    logic       i_clr_ovf;

    int tests;
    int fails;

    typedef struct {
        logic       md;
        logic [7:0] prod;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ec;
        logic       ef;
        logic       ee;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    mult_result_fifo #(
        .NB_DATA (4),
        .DEPTH   (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_mult_done (i_mult_done),
        .i_product   (i_product),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .i_clr_ovf   (i_clr_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(logic md, logic [7:0] prod, logic rdy, logic clr,
                                logic ev, logic [7:0] ed, logic [2:0] ec,
                                logic ef, logic ee, logic eo);
        vec_t v;
        v.md = md; v.prod = prod; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ef = ef; v.ee = ee; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic ev,
                           input logic [7:0] ed, input logic [2:0] ec,
                           input logic ef, input logic ee, input logic eo);
        chk({tag, ".valid"}, idx, 32'(o_valid), 32'(ev));
        chk({tag, ".data"}, idx, 32'(o_data), 32'(ed));
        chk({tag, ".count"}, idx, 32'(o_count), 32'(ec));
        chk({tag, ".full"}, idx, 32'(o_full), 32'(ef));
        chk({tag, ".empty"}, idx, 32'(o_empty), 32'(ee));
        chk({tag, ".ovf"}, idx, 32'(o_overflow), 32'(eo));
        chk({tag, ".full_and_empty"}, idx, 32'(o_full && o_empty), 32'(0));
    endtask

    task automatic step(input logic md, input logic [7:0] prod, input logic rdy,
                        input logic clr);
        i_mult_done = md;
        i_product   = prod;
        i_ready     = rdy;
        i_clr_ovf   = clr;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_mult_done = 1'b0;
        i_product   = '0;
        i_ready     = 1'b0;
        i_clr_ovf   = 1'b0;
        tests = 0;
        fails = 0;

        // single entry, hold, then pop
        vecs.push_back(mk(1, 8'h2D, 0, 0,  1, 8'h2D, 1, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0,  1, 8'h2D, 1, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0,  1, 8'h2D, 1, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0,  1, 8'h2D, 1, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 1, 0));
        // fill, drop FF, drain
        vecs.push_back(mk(1, 8'h01, 0, 0,  1, 8'h01, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h02, 0, 0,  1, 8'h01, 2, 0, 0, 0));
        vecs.push_back(mk(1, 8'h03, 0, 0,  1, 8'h01, 3, 0, 0, 0));
        vecs.push_back(mk(1, 8'h04, 0, 0,  1, 8'h01, 4, 1, 0, 0));
        vecs.push_back(mk(1, 8'hFF, 0, 0,  1, 8'h01, 4, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h02, 3, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h03, 2, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h04, 1, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 1, 1));
        // clear without a drop
        vecs.push_back(mk(0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 1, 0));
        // full with simultaneous push and pop
        vecs.push_back(mk(1, 8'h01, 0, 0,  1, 8'h01, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h02, 0, 0,  1, 8'h01, 2, 0, 0, 0));
        vecs.push_back(mk(1, 8'h03, 0, 0,  1, 8'h01, 3, 0, 0, 0));
        vecs.push_back(mk(1, 8'h04, 0, 0,  1, 8'h01, 4, 1, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 1, 0,  1, 8'h02, 4, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h03, 3, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h04, 2, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'hAA, 1, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 1, 0));
        // pointer wrap: streaming push/pop, occupancy stays at 1
        for (int k = 0; k < 10; k++) begin
            vecs.push_back(mk(1, 8'(8'h10 + k), 1, 0,  1, 8'(8'h10 + k), 1, 0, 0, 0));
        end
        vecs.push_back(mk(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 1, 0));
        // drop coinciding with clear: set wins, then a plain clear
        vecs.push_back(mk(1, 8'h01, 0, 0,  1, 8'h01, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8'h02, 0, 0,  1, 8'h01, 2, 0, 0, 0));
        vecs.push_back(mk(1, 8'h03, 0, 0,  1, 8'h01, 3, 0, 0, 0));
        vecs.push_back(mk(1, 8'h04, 0, 0,  1, 8'h01, 4, 1, 0, 0));
        vecs.push_back(mk(1, 8'hFF, 0, 1,  1, 8'h01, 4, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1,  1, 8'h01, 4, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h02, 3, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h03, 2, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h04, 1, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 1, 0));

        // reset, then idle
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(0, 8'h00, 0, 0);
            chk_all("idle", k, 0, 8'h00, 0, 0, 1, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].md, vecs[i].prod, vecs[i].rdy, vecs[i].clr);
            chk_all("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].ec,
                    vecs[i].ef, vecs[i].ee, vecs[i].eo);
        end

        // asynchronous reset while full with overflow set
        step(1, 8'h31, 0, 0);
        step(1, 8'h32, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h34, 0, 0);
        step(1, 8'h35, 0, 0);
        chk_all("pre_rst", 0, 1, 8'h31, 4, 1, 0, 1);
        i_mult_done = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 8'h00, 0, 0, 1, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // no same-cycle bypass: data appears only after the capturing edge
        i_mult_done = 1'b1;
        i_product   = 8'h5C;
        i_ready     = 1'b0;
        #1;
        chk_all("no_bypass", 0, 0, 8'h00, 0, 0, 1, 0);
        @(posedge i_clk);
        #1;
        chk_all("no_bypass", 1, 1, 8'h5C, 1, 0, 0, 0);
        step(0, 8'h00, 1, 0);
        chk_all("no_bypass", 2, 0, 8'h00, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mult_result_fifo.md
Name: mult_result_fifo

Overview:
- Downstream stage of the bit-serial multiplier.
- Captures the 2*NB_DATA-bit product on each one-cycle multiplication-done pulse from the multiplier FSM and stores it in a DEPTH-entry first-word-fall-through FIFO.
- Presents stored results to the consumer over a valid/ready handshake.
- Flags dropped results with a sticky overflow bit.

Parameters:
- NB_DATA, 4, operand width of the multiplier; product width is 2*NB_DATA.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_mult_done  input  1  one-cycle pulse from multiplier FSM; product valid in the same cycle.
- i_product  input  2*NB_DATA  multiplier product, sampled when i_mult_done=1.
- o_data  output  2*NB_DATA  head-of-FIFO result; forced to 0 when o_valid=0.
- o_valid  output  1  FIFO not empty.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- o_overflow  output  1  sticky; set when a result is dropped.
- i_clr_ovf  input  1  synchronous clear of o_overflow.

Behaviour:
- Reset (i_rst_n=0, asynchronous, takes effect immediately):
  - write/read pointers = 0, count = 0, o_overflow = 0.
  - Therefore o_valid=0, o_empty=1, o_full=0, o_data=0, o_count=0.
  - Storage array is not reset.
- Pop condition: o_valid && i_ready.
- Push condition: i_mult_done && (!o_full || pop).
- Push:
  - mem[wr_ptr] <= i_product at the clock edge.
  - wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop: rd_ptr increments, wrapping DEPTH-1 -> 0.
- o_data:
  - Combinational from mem[rd_ptr], gated to 0 when empty.
  - Holds stable while o_valid=1 and i_ready=0.
- Latency: a product pushed into an empty FIFO appears on o_data/o_valid the cycle after the i_mult_done edge. There is no same-cycle bypass.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full with i_mult_done=1 and no pop:
  - product dropped; pointers and count unchanged.
  - o_overflow <= 1 on that edge.
- Full with i_mult_done=1 and pop in the same cycle:
  - push accepted; count stays DEPTH.
  - o_overflow not set.
- Empty with i_ready=1: no pop, no pointer change.
- Clearing o_overflow:
  - i_clr_ovf=1 clears it on the next edge.
  - If a drop occurs in the same cycle as i_clr_ovf, set wins (o_overflow=1).
- Back-to-back i_mult_done pulses on consecutive cycles are each captured as separate entries. This is not produced by the FSM, but it must be supported.
- Reset mid-operation: all stored entries are discarded and the outputs return to reset values immediately, regardless of the clock.
- Implementation: pointers are $clog2(DEPTH) bits, and count is a separate register or derived from extended pointers. Either is acceptable provided the observable outputs match this specification.
- Invariants:
  - o_full and o_empty are never both 1.
  - o_count never exceeds DEPTH.

Test Plan (NB_DATA=4, DEPTH=4):
- Reset, then idle 5 cycles -> o_valid=0, o_empty=1, o_count=0, o_data=0, o_overflow=0. Assert i_rst_n low between clock edges -> outputs go to reset values immediately.
- Single push 8'h2D (i_ready=0) -> next cycle o_valid=1, o_data=8'h2D, o_count=1. Hold for 3 cycles with o_data stable. Raise i_ready -> next cycle o_valid=0, o_count=0.
- Push 8'h01, 8'h02, 8'h03, 8'h04 with i_ready=0 -> o_full=1, o_count=4. Fifth push 8'hFF -> dropped, o_overflow=1. Drain with i_ready=1 -> outputs 01, 02, 03, 04 in order; FF is never seen.
- Full FIFO (01..04); push 8'hAA in the same cycle as a pop -> o_count stays 4, o_overflow stays 0. Drain order is 02, 03, 04, AA.
- Pointer wrap: 10 push/pop pairs of 8'h10..8'h19 with i_ready=1 throughout -> every value emitted exactly once and in order; o_count never exceeds 1.
- With o_overflow=1, assert i_clr_ovf with no drop -> o_overflow=0 next cycle. Repeat with a simultaneous drop on a full FIFO -> o_overflow remains 1.
